// File: rtl/i2c_slave_if.sv
// Client-side handshake between i2c_slave and the local register/FIFO user.
interface i2c_slave_if;
  logic [7:0] iw_tx_data;   // next read byte, valid in the ow_tx_req cycle
  logic       iw_rx_ready;  // client can take a write byte
  logic [7:0] ow_rx_data;   // last received write byte
  logic       ow_rx_valid;  // one-cycle pulse, ow_rx_data is new
  logic       ow_tx_req;    // one-cycle pulse, present iw_tx_data now
  logic       ow_busy;      // matched transaction in progress
  logic       ow_rw;        // 1 = current transaction is a read

  modport slave (
    input  iw_tx_data, iw_rx_ready,
    output ow_rx_data, ow_rx_valid, ow_tx_req, ow_busy, ow_rw
  );
  modport master (
    output iw_tx_data, iw_rx_ready,
    input  ow_rx_data, ow_rx_valid, ow_tx_req, ow_busy, ow_rw
  );
endinterface

// File: rtl/i2c_slave.sv
// Oversampled 7-bit-address I2C target. SCL is only sampled (never stretched);
// SDA is open-drain and only changes one cycle after a detected SCL fall.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       iw_clk,
  input  logic       iw_reset_n,
  inout  wire        io_i2c_scl,
  inout  wire        io_i2c_sda,
  i2c_slave_if.slave cl
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;

  logic [1:0] scl_s, sda_s;
  logic       scl_d, sda_d;
  logic       scl_i, sda_i;
  logic       scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic       oe, oe_n;      // 1 = pull SDA low
  logic       ack, ack_n;    // write-byte ACK decision
  logic       ph, ph_n;      // ACK states: 0 = waiting for entry fall; READ: byte fully driven
  logic [7:0] rx_data, rx_data_n;
  logic       rx_valid, rx_valid_n;
  logic       busy, busy_n;
  logic       rw, rw_n;
  logic       tx_req;

  // Pin synchronisers plus one edge-detect stage; idle bus reads high
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], io_i2c_scl};
      sda_s <= {sda_s[0], io_i2c_sda};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
    end
  end

  assign scl_i    = scl_s[1];
  assign sda_i    = sda_s[1];
  assign scl_rise = scl_i & ~scl_d;
  assign scl_fall = ~scl_i & scl_d;
  assign start_c  = scl_i & scl_d & sda_d & ~sda_i;
  assign stop_c   = scl_i & scl_d & ~sda_d & sda_i;

  // State and datapath registers; reset releases SDA immediately
  always_ff @(posedge iw_clk or negedge iw_reset_n) begin
    if (!iw_reset_n) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      sh       <= 8'h00;
      oe       <= 1'b0;
      ack      <= 1'b0;
      ph       <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      oe       <= oe_n;
      ack      <= ack_n;
      ph       <= ph_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      busy     <= busy_n;
      rw       <= rw_n;
    end
  end

  // Next state: bus START/STOP override every bit-level event
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    oe_n       = oe;
    ack_n      = ack;
    ph_n       = ph;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    busy_n     = busy;
    rw_n       = rw;
    tx_req     = 1'b0;
    if (stop_c) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
      cnt_n   = 3'd0;
      ph_n    = 1'b0;
    end else if (start_c) begin
      // busy deliberately kept across a repeated START
      state_n = S_ADDR;
      cnt_n   = 3'd0;
      oe_n    = 1'b0;
      ph_n    = 1'b0;
    end else begin
      case (state)
        S_ADDR: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_i};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            // sh[6:0] already holds the seven address bits; sda_i is R/W
            if (sh[6:0] == ADDR) begin
              rw_n    = sda_i;
              busy_n  = 1'b1;
              ph_n    = 1'b0;
              state_n = S_ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          if (!ph) begin
            oe_n = 1'b1;
            ph_n = 1'b1;
            if (rw) begin
              tx_req = 1'b1;
              sh_n   = cl.iw_tx_data;
            end
          end else begin
            ph_n = 1'b0;
            if (rw) begin
              // the fall that ends the ACK also launches the first read bit
              oe_n    = ~sh[7];
              sh_n    = {sh[6:0], 1'b0};
              cnt_n   = 3'd1;
              state_n = S_READ;
            end else begin
              oe_n    = 1'b0;
              cnt_n   = 3'd0;
              state_n = S_WRITE;
            end
          end
        end
        S_WRITE: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_i};
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_n  = {sh[6:0], sda_i};
            rx_valid_n = 1'b1;
            ack_n      = cl.iw_rx_ready;
            ph_n       = 1'b0;
            state_n    = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!ph) begin
            oe_n = ack;
            ph_n = 1'b1;
          end else begin
            oe_n  = 1'b0;
            ph_n  = 1'b0;
            cnt_n = 3'd0;
            if (ack) begin
              state_n = S_WRITE;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IGNORE;
            end
          end
        end
        S_READ: if (scl_fall) begin
          if (ph) begin
            // eighth bit has been on the bus for a full high phase
            oe_n    = 1'b0;
            ph_n    = 1'b0;
            state_n = S_READ_ACK;
          end else begin
            oe_n  = ~sh[7];
            sh_n  = {sh[6:0], 1'b0};
            cnt_n = cnt + 3'd1;
            ph_n  = (cnt == 3'd7);
          end
        end
        S_READ_ACK: if (scl_rise) begin
          if (!sda_i) begin
            tx_req  = 1'b1;
            sh_n    = cl.iw_tx_data;
            cnt_n   = 3'd0;
            state_n = S_READ;
          end else begin
            busy_n  = 1'b0;
            state_n = S_IGNORE;
          end
        end
        default: ;  // IDLE and IGNORE only leave on START/STOP
      endcase
    end
  end

  assign io_i2c_sda     = oe ? 1'b0 : 1'bz;
  assign cl.ow_rx_data  = rx_data;
  assign cl.ow_rx_valid = rx_valid;
  assign cl.ow_tx_req   = tx_req;
  assign cl.ow_busy     = busy;
  assign cl.ow_rw       = rw;
endmodule
